mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

MEM-stage access controller plus MEM/WB pipeline register for the 5-stage MIPS pipeline. Consumes the registered MEM-stage control/data produced by the EXE/MEM register, performs loads and stores over a variable-latency data-memory handshake, stalls upstream while the bus is busy, and registers the write-back result for the WB stage.

## Interface
- MAX_WAIT, default 255: wait cycles tolerated after request before bus error (8-bit counter, 1..255).
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- MEM_RegW  in  1  instruction writes the register file.
- MEM_RegW_Src  in  1  1 = load (write-back from memory), 0 = ALU result.
- MEM_MemW  in  1  store.
- MEM_WBdst  in  5  destination register.
- MEM_instrOp  in  6  opcode; selects access width/sign.
- MEM_Alu_C  in  32  ALU result; effective address for loads/stores.
- MEM_RegFileA  in  32  register operand A.
- MEM_RegFileB  in  32  register operand B.
- MEM_MEMW_src  in  1  store-data select: 1 = MEM_RegFileA, 0 = MEM_RegFileB.
- dm_req  out  1  memory request, held until accepted.
- dm_we  out  1  1 = write.
- dm_be  out  4  byte enables, bit i = byte lane i (little-endian).
- dm_addr  out  32  word address ({MEM_Alu_C[31:2],2'b00}).
- dm_wdata  out  32  lane-replicated store data.
- dm_rdata  in  32  read data, valid when dm_ready=1.
- dm_ready  in  1  access completes at this rising edge.
- mem_stall  out  1  hold PC, IF/ID, ID/EXE, EXE/MEM this cycle.
- WB_RegW  out  1  write-back enable.
- WB_WBdst  out  5  write-back register.
- WB_data  out  32  write-back data.
- WB_exc  out  1  misaligned-access exception, one cycle.
- bus_err  out  1  sticky bus-timeout flag.

## Operation
- Opcodes: lb 0x20, lh 0x21, lw 0x23, lbu 0x24, lhu 0x25, sb 0x28, sh 0x29, sw 0x2B. Load with other op = lw; store with other op = sw.
- access = MEM_MemW | (MEM_RegW & MEM_RegW_Src). MemW has priority: when both set, treat as store, WB_RegW=0.
- Misaligned: half with addr[0]=1, word with addr[1:0]!=0. No dm_req, no stall; WB bubble with WB_exc=1.
- Store: dm_we=1; sb be=1<<addr[1:0], data byte replicated ×4; sh be=0011/1100 by addr[1], half replicated ×2; sw be=1111.
- Load: dm_we=0, dm_be=1111; extract lane by addr[1:0]/addr[1]; lb/lh sign-extend, lbu/lhu zero-extend.
- Non-access with MEM_RegW=1: WB_data = MEM_Alu_C.
- FSM: IDLE, WAIT, ERR.
  - IDLE: aligned access → dm_req=1; dm_ready=1 → complete, stay IDLE; else → WAIT, cnt=1, mem_stall=1.
  - WAIT: dm_req=1, addr/be/wdata stable; dm_ready=1 → complete, IDLE, mem_stall=0 that cycle; else cnt==MAX_WAIT → ERR, else cnt+1, mem_stall=1.
  - ERR: dm_req=0, mem_stall=1, bus_err=1, WB bubbles; exits only on rst.
- WB register: edge with mem_stall=0 loads computed result; edge with mem_stall=1 loads bubble (WB_RegW=0, WB_exc=0, WB_data/WBdst hold).

## Timing
- Reset: state IDLE, cnt 0, all WB_* 0, bus_err 0; dm_req/dm_we/dm_be 0 while rst high.
- dm_req, dm_we, dm_be, dm_addr, dm_wdata, mem_stall combinational from state and MEM_* inputs; WB_* and bus_err registered.
- Zero-wait memory: 1 cycle per access, no stall; WB_* valid the cycle after.
- N wait cycles: mem_stall high N cycles; load data captured at the dm_ready edge.
- dm_ready while dm_req=0 ignored. Reset mid-WAIT abandons access; dm_req drops immediately.
- Ready at cnt==MAX_WAIT edge: completion wins over timeout.

## Structure
- Shared package mips_pkg: opcode localparams, FSM state enum, width constants.
- Sub-module mem_lane_align (combinational): be/wdata replication and load extraction/extension; FSM, counter, WB register in top.

## Test plan
- lw, addr 0x100, rdata 0xDEADBEEF, ready same cycle → no stall; next cycle WB_RegW=1, WB_data=0xDEADBEEF.
- lb addr 0x103, rdata 0x80112233, ready after 3 waits → mem_stall 3 cycles; WB_data=0xFFFFFF80; lbu gives 0x00000080.
- sh addr 0x102, MEMW_src=0, RegFileB=0x1234ABCD → dm_be=1100, dm_wdata=0xABCDABCD, dm_we=1, WB_RegW=0.
- lw addr 0x101 → no dm_req, no stall; WB_exc=1 one cycle, WB_RegW=0.
- ready never, MAX_WAIT=4 → stall, bus_err=1 after 4 wait cycles, stays until rst; rst clears all.
- rst asserted mid-WAIT → dm_req 0 at once, WB_* 0; post-reset sw accepted normally.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline: opcodes, access sizes and MEM-stage FSM states.
package mips_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned REGW = 5;
    localparam int unsigned CNTW = 8;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store enables/replication and load lane extraction with extension.
module mem_lane_align
    import mips_pkg::*;
(
    input  logic [1:0]      addr_lo,
    input  size_e           size,
    input  logic            sign_ext,
    input  logic [XLEN-1:0] st_data,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      st_be,
    output logic [XLEN-1:0] st_wdata,
    output logic [XLEN-1:0] ld_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        st_be    = 4'b1111;
        st_wdata = st_data;
        ld_data  = rdata;
        case (size)
            SZ_BYTE: begin
                st_be    = 4'b0001 << addr_lo;
                st_wdata = {4{st_data[7:0]}};
                ld_data  = sign_ext ? {{24{byte_sel[7]}}, byte_sel} : {24'd0, byte_sel};
            end
            SZ_HALF: begin
                st_be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{st_data[15:0]}};
                ld_data  = sign_ext ? {{16{half_sel[15]}}, half_sel} : {16'd0, half_sel};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = st_data;
                ld_data  = rdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM-stage data-memory access controller with bus-timeout FSM and MEM/WB pipeline register.
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            MEM_RegW,
    input  logic            MEM_RegW_Src,
    input  logic            MEM_MemW,
    input  logic [4:0]      MEM_WBdst,
    input  logic [5:0]      MEM_instrOp,
    input  logic [31:0]     MEM_Alu_C,
    input  logic [31:0]     MEM_RegFileA,
    input  logic [31:0]     MEM_RegFileB,
    input  logic            MEM_MEMW_src,
    output logic            dm_req,
    output logic            dm_we,
    output logic [3:0]      dm_be,
    output logic [31:0]     dm_addr,
    output logic [31:0]     dm_wdata,
    input  logic [31:0]     dm_rdata,
    input  logic            dm_ready,
    output logic            mem_stall,
    output logic            WB_RegW,
    output logic [4:0]      WB_WBdst,
    output logic [31:0]     WB_data,
    output logic            WB_exc,
    output logic            bus_err
);

    mem_state_e      state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            wb_regw_q, wb_regw_d;
    logic [REGW-1:0] wb_dst_q, wb_dst_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic            wb_exc_q, wb_exc_d;
    logic            bus_err_q, bus_err_d;

    logic            is_store, is_load, access, misaligned, req_ok;
    logic            req_c, stall_c, sign_ext;
    size_e           size;
    logic [3:0]      st_be;
    logic [XLEN-1:0] st_data, st_wdata, ld_data;

    // Access decode; a store takes priority over a load flagged on the same instruction.
    always_comb begin
        is_store = MEM_MemW;
        is_load  = MEM_RegW & MEM_RegW_Src & ~MEM_MemW;
        access   = is_store | is_load;
        size     = SZ_WORD;
        sign_ext = 1'b0;
        if (is_store) begin
            case (MEM_instrOp)
                OP_SB:   size = SZ_BYTE;
                OP_SH:   size = SZ_HALF;
                default: size = SZ_WORD;
            endcase
        end else begin
            case (MEM_instrOp)
                OP_LB:   begin size = SZ_BYTE; sign_ext = 1'b1; end
                OP_LBU:  size = SZ_BYTE;
                OP_LH:   begin size = SZ_HALF; sign_ext = 1'b1; end
                OP_LHU:  size = SZ_HALF;
                default: size = SZ_WORD;
            endcase
        end
        misaligned = access & (((size == SZ_HALF) & MEM_Alu_C[0]) |
                               ((size == SZ_WORD) & (MEM_Alu_C[1:0] != 2'b00)));
        req_ok     = access & ~misaligned;
        st_data    = MEM_MEMW_src ? MEM_RegFileA : MEM_RegFileB;
    end

    mem_lane_align u_align (
        .addr_lo  (MEM_Alu_C[1:0]),
        .size     (size),
        .sign_ext (sign_ext),
        .st_data  (st_data),
        .rdata    (dm_rdata),
        .st_be    (st_be),
        .st_wdata (st_wdata),
        .ld_data  (ld_data)
    );

    // Handshake FSM: a completing dm_ready beats the timeout on the final wait cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_c   = 1'b0;
        stall_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_ok) begin
                    req_c = 1'b1;
                    if (!dm_ready) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNTW'(1);
                        stall_c = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                req_c = 1'b1;
                if (dm_ready) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNTW'(MAX_WAIT)) begin
                    state_d = ST_ERR;
                    stall_c = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNTW'(1);
                    stall_c = 1'b1;
                end
            end
            ST_ERR: begin
                stall_c = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Write-back next value; a stalled edge inserts a bubble and holds data/destination.
    always_comb begin
        wb_regw_d = 1'b0;
        wb_exc_d  = 1'b0;
        wb_dst_d  = wb_dst_q;
        wb_data_d = wb_data_q;
        bus_err_d = bus_err_q | (state_d == ST_ERR);
        if (!stall_c) begin
            wb_exc_d  = misaligned;
            wb_regw_d = MEM_RegW & ~MEM_MemW & ~misaligned;
            if (wb_regw_d) begin
                wb_dst_d  = MEM_WBdst;
                wb_data_d = is_load ? ld_data : MEM_Alu_C;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            wb_regw_q <= 1'b0;
            wb_dst_q  <= '0;
            wb_data_q <= '0;
            wb_exc_q  <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wb_regw_q <= wb_regw_d;
            wb_dst_q  <= wb_dst_d;
            wb_data_q <= wb_data_d;
            wb_exc_q  <= wb_exc_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign dm_req    = req_c & ~rst;
    assign dm_we     = dm_req & is_store;
    assign dm_be     = dm_req ? (is_store ? st_be : 4'b1111) : 4'b0000;
    assign dm_addr   = {MEM_Alu_C[31:2], 2'b00};
    assign dm_wdata  = st_wdata;
    assign mem_stall = stall_c;

    assign WB_RegW  = wb_regw_q;
    assign WB_WBdst = wb_dst_q;
    assign WB_data  = wb_data_q;
    assign WB_exc   = wb_exc_q;
    assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: zero-wait vector table plus wait, timeout and reset sequences.
module tb_mem_wb_stage;

    logic        clk, rst;
    logic        MEM_RegW, MEM_RegW_Src, MEM_MemW, MEM_MEMW_src;
    logic [4:0]  MEM_WBdst;
    logic [5:0]  MEM_instrOp;
    logic [31:0] MEM_Alu_C, MEM_RegFileA, MEM_RegFileB;
    logic        dm_req, dm_we, dm_ready, mem_stall;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        WB_RegW, WB_exc, bus_err;
    logic [4:0]  WB_WBdst;
    logic [31:0] WB_data;

    int n_tests = 0;
    int n_fail  = 0;

    mem_wb_stage #(.MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .MEM_RegW(MEM_RegW), .MEM_RegW_Src(MEM_RegW_Src), .MEM_MemW(MEM_MemW),
        .MEM_WBdst(MEM_WBdst), .MEM_instrOp(MEM_instrOp), .MEM_Alu_C(MEM_Alu_C),
        .MEM_RegFileA(MEM_RegFileA), .MEM_RegFileB(MEM_RegFileB), .MEM_MEMW_src(MEM_MEMW_src),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_stall(mem_stall), .WB_RegW(WB_RegW), .WB_WBdst(WB_WBdst),
        .WB_data(WB_data), .WB_exc(WB_exc), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic        regw, src, memw, msrc;
        logic [31:0] alu, ra, rb, rdata;
        logic        e_req, e_we;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_wb_regw, e_wb_exc;
        logic [31:0] e_wb_data;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [5:0] op, input logic regw, input logic src, input logic memw,
                         input logic [31:0] alu, input logic [31:0] ra, input logic [31:0] rb,
                         input logic msrc, input logic [4:0] dst);
        MEM_instrOp  = op;
        MEM_RegW     = regw;
        MEM_RegW_Src = src;
        MEM_MemW     = memw;
        MEM_Alu_C    = alu;
        MEM_RegFileA = ra;
        MEM_RegFileB = rb;
        MEM_MEMW_src = msrc;
        MEM_WBdst    = dst;
    endtask

    function automatic vec_t mk(input logic [5:0] op, input logic regw, input logic src,
                                input logic memw, input logic msrc, input logic [31:0] alu,
                                input logic [31:0] ra, input logic [31:0] rb, input logic [31:0] rdata,
                                input logic e_req, input logic e_we, input logic [3:0] e_be,
                                input logic [31:0] e_wdata, input logic e_wb_regw,
                                input logic e_wb_exc, input logic [31:0] e_wb_data);
        vec_t v;
        v.op = op; v.regw = regw; v.src = src; v.memw = memw; v.msrc = msrc;
        v.alu = alu; v.ra = ra; v.rb = rb; v.rdata = rdata;
        v.e_req = e_req; v.e_we = e_we; v.e_be = e_be; v.e_wdata = e_wdata;
        v.e_wb_regw = e_wb_regw; v.e_wb_exc = e_wb_exc; v.e_wb_data = e_wb_data;
        return v;
    endfunction

    initial begin
        //            op     rw src mw ms  alu           ra            rb            rdata         req we be       wdata         wbrw exc wbdata
        vecs[0]  = mk(6'h23, 1, 1, 0, 0, 32'h00000100, 32'h0,        32'h0,        32'hDEADBEEF, 1, 0, 4'b1111, 32'h0,        1, 0, 32'hDEADBEEF);
        vecs[1]  = mk(6'h29, 0, 0, 1, 0, 32'h00000102, 32'h0,        32'h1234ABCD, 32'h0,        1, 1, 4'b1100, 32'hABCDABCD, 0, 0, 32'h0);
        vecs[2]  = mk(6'h23, 1, 1, 0, 0, 32'h00000101, 32'h0,        32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        0, 1, 32'h0);
        vecs[3]  = mk(6'h24, 1, 1, 0, 0, 32'h00000103, 32'h0,        32'h0,        32'h80112233, 1, 0, 4'b1111, 32'h0,        1, 0, 32'h00000080);
        vecs[4]  = mk(6'h20, 1, 1, 0, 0, 32'h00000103, 32'h0,        32'h0,        32'h80112233, 1, 0, 4'b1111, 32'h0,        1, 0, 32'hFFFFFF80);
        vecs[5]  = mk(6'h21, 1, 1, 0, 0, 32'h00000102, 32'h0,        32'h0,        32'h80112233, 1, 0, 4'b1111, 32'h0,        1, 0, 32'hFFFF8011);
        vecs[6]  = mk(6'h25, 1, 1, 0, 0, 32'h00000100, 32'h0,        32'h0,        32'h80112233, 1, 0, 4'b1111, 32'h0,        1, 0, 32'h00002233);
        vecs[7]  = mk(6'h28, 0, 0, 1, 1, 32'h00000101, 32'h000000A5, 32'h0,        32'h0,        1, 1, 4'b0010, 32'hA5A5A5A5, 0, 0, 32'h0);
        vecs[8]  = mk(6'h2B, 0, 0, 1, 0, 32'h00000200, 32'h0,        32'h11223344, 32'h0,        1, 1, 4'b1111, 32'h11223344, 0, 0, 32'h0);
        vecs[9]  = mk(6'h00, 1, 0, 0, 0, 32'hCAFE0001, 32'h0,        32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        1, 0, 32'hCAFE0001);
        vecs[10] = mk(6'h21, 1, 1, 0, 0, 32'h00000103, 32'h0,        32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        0, 1, 32'h0);
        vecs[11] = mk(6'h2B, 1, 1, 1, 0, 32'h00000204, 32'h0,        32'h55AA55AA, 32'h0,        1, 1, 4'b1111, 32'h55AA55AA, 0, 0, 32'h0);
        vecs[12] = mk(6'h00, 1, 1, 0, 0, 32'h00000104, 32'h0,        32'h0,        32'h0BADF00D, 1, 0, 4'b1111, 32'h0,        1, 0, 32'h0BADF00D);
        vecs[13] = mk(6'h29, 0, 0, 1, 0, 32'h00000101, 32'h0,        32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        0, 1, 32'h0);

        rst = 1'b1;
        dm_ready = 1'b0;
        dm_rdata = '0;
        drive(6'h00, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 5'd0);
        #12;
        check("rst_req", 32'(dm_req), 32'h0);
        check("rst_wb_regw", 32'(WB_RegW), 32'h0);
        check("rst_wb_data", WB_data, 32'h0);
        check("rst_bus_err", 32'(bus_err), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Zero-wait table: combinational outputs before the edge, WB after it.
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].op, vecs[i].regw, vecs[i].src, vecs[i].memw, vecs[i].alu,
                  vecs[i].ra, vecs[i].rb, vecs[i].msrc, 5'(i + 1));
            dm_rdata = vecs[i].rdata;
            dm_ready = 1'b1;
            #1;
            check($sformatf("v%0d_req", i), 32'(dm_req), 32'(vecs[i].e_req));
            check($sformatf("v%0d_stall", i), 32'(mem_stall), 32'h0);
            if (vecs[i].e_req) begin
                check($sformatf("v%0d_we", i), 32'(dm_we), 32'(vecs[i].e_we));
                check($sformatf("v%0d_be", i), 32'(dm_be), 32'(vecs[i].e_be));
                check($sformatf("v%0d_addr", i), dm_addr, {vecs[i].alu[31:2], 2'b00});
            end
            if (vecs[i].e_we)
                check($sformatf("v%0d_wdata", i), dm_wdata, vecs[i].e_wdata);
            step();
            check($sformatf("v%0d_wb_regw", i), 32'(WB_RegW), 32'(vecs[i].e_wb_regw));
            check($sformatf("v%0d_wb_exc", i), 32'(WB_exc), 32'(vecs[i].e_wb_exc));
            if (vecs[i].e_wb_regw) begin
                check($sformatf("v%0d_wb_data", i), WB_data, vecs[i].e_wb_data);
                check($sformatf("v%0d_wb_dst", i), 32'(WB_WBdst), 32'(i + 1));
            end
        end

        // lb with three wait cycles.
        drive(6'h20, 1, 1, 0, 32'h00000103, 32'h0, 32'h0, 0, 5'd7);
        dm_ready = 1'b0;
        dm_rdata = 32'h80112233;
        for (int w = 0; w < 3; w++) begin
            #1;
            check($sformatf("wait%0d_stall", w), 32'(mem_stall), 32'h1);
            check($sformatf("wait%0d_req", w), 32'(dm_req), 32'h1);
            step();
            check($sformatf("wait%0d_wb_bubble", w), 32'(WB_RegW), 32'h0);
        end
        dm_ready = 1'b1;
        #1;
        check("wait_done_stall", 32'(mem_stall), 32'h0);
        step();
        check("wait_wb_regw", 32'(WB_RegW), 32'h1);
        check("wait_wb_data", WB_data, 32'hFFFFFF80);
        check("wait_wb_dst", 32'(WB_WBdst), 32'd7);

        // Bus that never answers: error after MAX_WAIT wait cycles, sticky until reset.
        drive(6'h2B, 0, 0, 1, 32'h00000300, 32'h0, 32'h0BEEF000, 0, 5'd0);
        dm_ready = 1'b0;
        for (int w = 0; w < 5; w++) begin
            #1;
            check($sformatf("to%0d_stall", w), 32'(mem_stall), 32'h1);
            check($sformatf("to%0d_bus_err", w), 32'(bus_err), 32'h0);
            step();
        end
        check("to_bus_err_set", 32'(bus_err), 32'h1);
        check("to_err_req", 32'(dm_req), 32'h0);
        check("to_err_stall", 32'(mem_stall), 32'h1);
        dm_ready = 1'b1;
        step();
        step();
        check("to_err_sticky", 32'(bus_err), 32'h1);
        check("to_err_stall2", 32'(mem_stall), 32'h1);
        rst = 1'b1;
        #1;
        check("to_rst_bus_err", 32'(bus_err), 32'h0);
        check("to_rst_stall", 32'(mem_stall), 32'h0);
        step();
        rst = 1'b0;

        // Reset in the middle of a wait abandons the access.
        drive(6'h23, 1, 1, 0, 32'h00000400, 32'h0, 32'h0, 0, 5'd9);
        dm_ready = 1'b0;
        step();
        step();
        check("mid_wait_stall", 32'(mem_stall), 32'h1);
        rst = 1'b1;
        #1;
        check("mid_rst_req", 32'(dm_req), 32'h0);
        check("mid_rst_be", 32'(dm_be), 32'h0);
        check("mid_rst_wb_regw", 32'(WB_RegW), 32'h0);
        check("mid_rst_wb_data", WB_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(6'h2B, 0, 0, 1, 32'h00000040, 32'h0, 32'h01020304, 0, 5'd0);
        dm_ready = 1'b1;
        #1;
        check("post_rst_req", 32'(dm_req), 32'h1);
        check("post_rst_we", 32'(dm_we), 32'h1);
        check("post_rst_stall", 32'(mem_stall), 32'h0);
        check("post_rst_wdata", dm_wdata, 32'h01020304);
        step();
        check("post_rst_wb_regw", 32'(WB_RegW), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
